// File: rtl/mag_cmp_seq_if.sv
// mag_cmp_seq_if: request/result bundle for the sequential magnitude comparator.
//   start, a, b                    : compare request and unsigned operands (master -> slave)
//   ready, done                    : idle indicator and one-cycle result-valid pulse (slave -> master)
//   agtb, aeqb, altb, ageb         : registered compare results (slave -> master)
interface mag_cmp_seq_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic             agtb;
    logic             aeqb;
    logic             altb;
    logic             ageb;

    modport master (
        output start, a, b,
        input  ready, done, agtb, aeqb, altb, ageb
    );

    modport slave (
        input  start, a, b,
        output ready, done, agtb, aeqb, altb, ageb
    );
endinterface

// File: rtl/mag_cmp_seq.sv
// mag_cmp_seq: unsigned magnitude comparator that walks the operands SLICE bits
// per cycle, most significant slice first (IDLE -> RUN x N -> DONE -> IDLE).
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset
//   bus    : mag_cmp_seq_if.slave (start/a/b in; ready/done/agtb/aeqb/altb/ageb out)
// Build option:
//   MAG_CMP_EARLY_EXIT_EN : when defined, RUN ends right after the first unequal
//                           slice; otherwise all N slices are always walked.
module mag_cmp_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 2
) (
    input  logic          clk,
    input  logic          reset,
    mag_cmp_seq_if.slave  bus
);
    localparam int unsigned N     = WIDTH / SLICE;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             agtb_q, agtb_d;
    logic             aeqb_q, aeqb_d;
    logic             altb_q, altb_d;
    logic             ageb_q, ageb_d;
    logic             slice_gt, slice_lt, finish;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            agtb_q  <= 1'b0;
            aeqb_q  <= 1'b0;
            altb_q  <= 1'b0;
            ageb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            agtb_q  <= agtb_d;
            aeqb_q  <= aeqb_d;
            altb_q  <= altb_d;
            ageb_q  <= ageb_d;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        eq_d     = eq_q;
        gt_d     = gt_q;
        lt_d     = lt_q;
        agtb_d   = agtb_q;
        aeqb_d   = aeqb_q;
        altb_d   = altb_q;
        ageb_d   = ageb_q;
        slice_gt = 1'b0;
        slice_lt = 1'b0;
        finish   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    idx_d   = IDX_W'(N - 1);
                    eq_d    = 1'b1;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                end
            end
            S_RUN: begin
                // Operands are shifted left so the slice under test is always on top
                slice_gt = (a_q[WIDTH-1 -: SLICE] > b_q[WIDTH-1 -: SLICE]);
                slice_lt = (a_q[WIDTH-1 -: SLICE] < b_q[WIDTH-1 -: SLICE]);
                a_d      = a_q << SLICE;
                b_d      = b_q << SLICE;
                if (idx_q != '0) begin
                    idx_d = idx_q - IDX_W'(1);
                end
                // Only the first unequal slice decides the outcome
                if (eq_q && (slice_gt || slice_lt)) begin
                    eq_d = 1'b0;
                    gt_d = slice_gt;
                    lt_d = slice_lt;
                end
                finish = (idx_q == '0);
`ifdef MAG_CMP_EARLY_EXIT_EN
                finish = finish || (eq_q && (slice_gt || slice_lt));
`endif
                // Results are loaded on entry to DONE so they are valid with done
                if (finish) begin
                    state_d = S_DONE;
                    agtb_d  = gt_d;
                    aeqb_d  = eq_d;
                    altb_d  = lt_d;
                    ageb_d  = gt_d | eq_d;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    assign bus.ready = ready_q;
    assign bus.done  = done_q;
    assign bus.agtb  = agtb_q;
    assign bus.aeqb  = aeqb_q;
    assign bus.altb  = altb_q;
    assign bus.ageb  = ageb_q;
endmodule

// File: tb/tb_mag_cmp_seq.sv
// tb_mag_cmp_seq: directed and randomized checks of mag_cmp_seq against an
// arithmetic reference (flags from a>b / a==b / a<b, latency from slice prefixes).
// Honours MAG_CMP_EARLY_EXIT_EN the same way as the design.
module tb_mag_cmp_seq;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned SLICE = 2;
    localparam int unsigned N     = WIDTH / SLICE;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mag_cmp_seq_if #(.WIDTH(WIDTH)) bus ();

    mag_cmp_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected cycles from start (cycle 0) to done
    function automatic int ref_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int k;
        k = N;
        for (int i = N; i >= 1; i--) begin
            if ((a >> (WIDTH - i * SLICE)) != (b >> (WIDTH - i * SLICE))) k = i;
        end
`ifdef MAG_CMP_EARLY_EXIT_EN
        return k + 1;
`else
        return (k > 0) ? N + 1 : N + 1;
`endif
    endfunction

    task automatic run_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit perturb);
        int lat;
        bit seen;
        check("ready_idle", 32'(bus.ready), 32'd1);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        tick();
        bus.start = 1'b0;
        check("ready_busy", 32'(bus.ready), 32'd0);
        seen = 1'b0;
        lat  = 0;
        for (int c = 1; c <= int'(N) + 4 && !seen; c++) begin
            if (bus.done) begin
                seen = 1'b1;
                lat  = c;
            end else begin
                if (perturb && c == 3) begin
                    bus.start = 1'b1;
                    bus.a     = ~a;
                    bus.b     = ~b;
                end else if (perturb && c == 4) begin
                    bus.start = 1'b0;
                end
                tick();
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        check("latency", 32'(lat), 32'(ref_lat(a, b)));
        check("agtb", 32'(bus.agtb), 32'(a > b));
        check("aeqb", 32'(bus.aeqb), 32'(a == b));
        check("altb", 32'(bus.altb), 32'(a < b));
        check("ageb", 32'(bus.ageb), 32'(a >= b));
        tick();
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("agtb_hold", 32'(bus.agtb), 32'(a > b));
        check("aeqb_hold", 32'(bus.aeqb), 32'(a == b));
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        int dones;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_flags", 32'({bus.agtb, bus.aeqb, bus.altb, bus.ageb}), 32'd0);

        run_cmp(16'h1234, 16'h1234, 1'b0);
        run_cmp(16'h8000, 16'h0000, 1'b0);
        run_cmp(16'h0001, 16'h0002, 1'b1);

        // Abort mid-operation; reset also overrides a simultaneous start
        bus.start = 1'b1;
        bus.a     = 16'hFFFF;
        bus.b     = 16'h0000;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        reset     = 1'b1;
        bus.start = 1'b1;
        tick();
        reset     = 1'b0;
        bus.start = 1'b0;
        check("abort_ready", 32'(bus.ready), 32'd1);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_flags", 32'({bus.agtb, bus.aeqb, bus.altb, bus.ageb}), 32'd0);
        dones = 0;
        for (int i = 0; i < int'(N) + 4; i++) begin
            if (bus.done) dones++;
            tick();
        end
        check("abort_no_done", 32'(dones), 32'd0);
        run_cmp(16'hFFFF, 16'h0000, 1'b0);

        // Back-to-back random compares, biased toward shared high-order prefixes
        for (int n = 0; n < 1000; n++) begin
            ra = WIDTH'($urandom);
            case ($urandom_range(0, 2))
                0:       rb = WIDTH'($urandom);
                1:       rb = ra;
                default: rb = ra ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
            endcase
            run_cmp(ra, rb, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mag_cmp_seq.md
MAG_CMP_SEQ -- requirements
Module: mag_cmp_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width in bits.
REQ-002 SHALL have parameter SLICE, default 2: bits compared per cycle; WIDTH SHALL be an integer multiple of SLICE; N = WIDTH/SLICE.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: request a compare; honoured only while ready=1.
REQ-006 SHALL have port a, input, WIDTH: operand A, unsigned.
REQ-007 SHALL have port b, input, WIDTH: operand B, unsigned.
REQ-008 SHALL have port ready, output, 1: high only in IDLE.
REQ-009 SHALL have port done, output, 1: one-cycle pulse marking valid results.
REQ-010 SHALL have port agtb, output, 1: registered result, A > B.
REQ-011 SHALL have port aeqb, output, 1: registered result, A == B.
REQ-012 SHALL have port altb, output, 1: registered result, A < B.
REQ-013 SHALL have port ageb, output, 1: registered result, A >= B.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 In IDLE with start=1, SHALL capture a and b into internal registers, set slice index to N-1 and the eq-so-far flag to 1, and enter RUN next cycle.
REQ-016 start while ready=0 SHALL be ignored; a and b changing after capture SHALL NOT affect the result.
REQ-017 Each RUN cycle SHALL compare one SLICE-bit slice of the captured operands, MSB slice first, index decrementing by 1.
REQ-018 On the first unequal slice, SHALL latch gt/lt from that slice; later slices SHALL NOT alter the outcome.
REQ-019 After the slice at index 0, SHALL enter DONE; the index SHALL NOT wrap.
REQ-020 In DONE, SHALL assert done=1 for exactly one cycle, update agtb/aeqb/altb/ageb, and return to IDLE next cycle.
REQ-021 Result flags: exactly one of agtb, aeqb, altb SHALL be 1; ageb SHALL equal agtb|aeqb.
REQ-022 Result flags SHALL hold their value until the next DONE.
REQ-023 Latency, start accepted in cycle 0, without the early exit of REQ-028: done SHALL be high in cycle N+1.
REQ-024 start asserted in the same cycle that the FSM returns to IDLE SHALL be accepted in the following cycle, when ready=1; back-to-back throughput SHALL be one compare per N+2 cycles.

Reset
REQ-025 reset=1 at a clock edge SHALL force: state IDLE, ready=1, done=0, agtb=0, aeqb=0, altb=0, ageb=0, internal registers 0.
REQ-026 reset during RUN or DONE SHALL abort the operation; no done pulse SHALL follow.
REQ-027 reset SHALL dominate start in the same cycle.

Configuration
REQ-028 Macro MAG_CMP_EARLY_EXIT_EN defined: RUN SHALL go to DONE in the cycle after the first unequal slice; latency SHALL be k+1, where k is the RUN cycle (1..N) holding the first unequal slice; equal operands SHALL still take N+1.
REQ-029 Macro MAG_CMP_EARLY_EXIT_EN undefined: all N slices SHALL always be processed; latency SHALL be fixed at N+1; results SHALL be identical in both builds.

Verification (WIDTH=16, SLICE=2, N=8; start high in cycle 0)
REQ-030 Reset for 2 cycles, then release -> ready=1, done=0, all result flags 0.
REQ-031 a=0x1234, b=0x1234 -> done in cycle 9 (both builds), aeqb=1, ageb=1, agtb=0, altb=0.
REQ-032 a=0x8000, b=0x0000 -> agtb=1, ageb=1; done in cycle 2 with MAG_CMP_EARLY_EXIT_EN, cycle 9 without.
REQ-033 a=0x0001, b=0x0002 -> altb=1, ageb=0, done in cycle 9 (both builds); start pulsed and a changed during RUN -> no effect on the result.
REQ-034 a=0xFFFF, b=0x0000, reset asserted in cycle 4 -> no done pulse, outputs 0; a new start then completes normally.
REQ-035 Random a/b, 1000 back-to-back compares in both builds -> flags match the reference a>b, a==b, a<b, and done spacing matches REQ-023/REQ-028.
